// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - Shared ALU opcode, forwarding-select and FSM state types for the execute stage.
package execute_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100,
    ALU_MUL   = 4'b1000
  } alu_op_t;

  // Code 2'b11 is reserved and selects the register-file value like FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } exe_state_t;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - Iterative shift-add multiplier, one partial product per cycle, low N bits kept.
module mul_iter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] product_o
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // done is held for exactly one cycle after the N-th step so the owner can capture acc_q.
  assign done_o    = busy_q && (cnt_q == CW'(N));
  assign busy_o    = busy_q;
  assign product_o = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (done_o) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - LEGv8 execute stage: forwarding muxes, ALU, branch target, registered EX/MEM outputs.
// Define EXECUTE_MUL_EN to run AluControl 1000 on the iterative mul_iter multiplier.
module execute_pipe
  import execute_pkg::*;
#(
  parameter int N        = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [1:0]   fwdA,
  input  logic [1:0]   fwdB,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [N-1:0] memResult,
  input  logic [N-1:0] wbResult,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         zero_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M
);

  logic [N-1:0] fwd_a, fwd_b, op_b, alu_res, pc_branch;
  logic         accept;

  exe_state_t   state_q, state_d;
  logic         valid_q, valid_d;
  logic         zero_q, zero_d;
  logic [N-1:0] pcb_q, pcb_d;
  logic [N-1:0] res_q, res_d;
  logic [N-1:0] wdata_q, wdata_d;

  always_comb begin
    case (fwdA)
      FWD_WB:  fwd_a = wbResult;
      FWD_MEM: fwd_a = memResult;
      default: fwd_a = readData1_E;
    endcase
    case (fwdB)
      FWD_WB:  fwd_b = wbResult;
      FWD_MEM: fwd_b = memResult;
      default: fwd_b = readData2_E;
    endcase
  end

  assign op_b      = AluSrc ? signImm_E : fwd_b;
  assign pc_branch = PC_E + (signImm_E << BR_SHIFT);

  // MUL is not handled here: it yields 0 in the single-cycle path and the multiplier supplies it otherwise.
  always_comb begin
    alu_res = '0;
    case (AluControl)
      ALU_AND:   alu_res = fwd_a & op_b;
      ALU_OR:    alu_res = fwd_a | op_b;
      ALU_ADD:   alu_res = fwd_a + op_b;
      ALU_SUB:   alu_res = fwd_a - op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_NOR:   alu_res = ~(fwd_a | op_b);
      default:   alu_res = '0;
    endcase
  end

  assign ready_o = (state_q == ST_RUN) && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;

`ifdef EXECUTE_MUL_EN
  logic         mul_start, mul_busy, mul_done;
  logic [N-1:0] mul_prod, pcb_hold_q, wdata_hold_q;

  mul_iter #(
    .N(N)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start),
    .a_i      (fwd_a),
    .b_i      (op_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  // Side results of a multiply are captured at acceptance so forwarding changes cannot reach them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcb_hold_q   <= '0;
      wdata_hold_q <= '0;
    end else if (mul_start) begin
      pcb_hold_q   <= pc_branch;
      wdata_hold_q <= fwd_b;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    pcb_d   = pcb_q;
    res_d   = res_q;
    wdata_d = wdata_q;
`ifdef EXECUTE_MUL_EN
    mul_start = 1'b0;
`endif
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    case (state_q)
      ST_RUN: begin
        if (accept) begin
`ifdef EXECUTE_MUL_EN
          if (AluControl == ALU_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
`else
          begin
`endif
            valid_d = 1'b1;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            pcb_d   = pc_branch;
            wdata_d = fwd_b;
          end
        end
      end
      ST_MUL: begin
`ifdef EXECUTE_MUL_EN
        if (mul_done) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          res_d   = mul_prod;
          zero_d  = (mul_prod == '0);
          pcb_d   = pcb_hold_q;
          wdata_d = wdata_hold_q;
        end else if (!mul_busy) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      pcb_q   <= '0;
      res_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      pcb_q   <= pcb_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
    end
  end

  assign valid_o     = valid_q;
  assign zero_M      = zero_q;
  assign PCBranch_M  = pcb_q;
  assign aluResult_M = res_q;
  assign writeData_M = wdata_q;

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Registered, parametrised execute stage for the LEGv8 pipeline. Its outputs drive the EX/MEM boundary.
- Computes:
  - the branch target PC + (signImm << 2);
  - the ALU result on forwarded operands;
  - the zero flag.
- Captures all results into an output register with a valid/ready handshake, so the stage can stall and hold results.
- Optionally hosts an iterative multi-cycle multiplier that stalls upstream while busy.

Parameters:
- N, 64, datapath width in bits; must be at least 8.
- BR_SHIFT, 2, left shift applied to signImm for the branch offset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  upstream presents an operation
- ready_o  out  1  stage can accept this cycle
- AluSrc  in  1  0: operand B = readData2 path; 1: operand B = signImm_E
- AluControl  in  4  ALU operation code
- fwdA  in  2  operand A source: 00 readData1_E, 01 wbResult, 10 memResult, 11 reserved (treated as 00)
- fwdB  in  2  same encoding for the readData2 path
- PC_E  in  N  instruction PC
- signImm_E  in  N  sign-extended immediate
- readData1_E  in  N  register file port 1
- readData2_E  in  N  register file port 2
- memResult  in  N  forwarded value from the MEM stage
- wbResult  in  N  forwarded value from the WB stage
- valid_o  out  1  output register holds a valid result
- ready_i  in  1  downstream accepts
- zero_M  out  1  aluResult_M == 0
- PCBranch_M  out  N  branch target
- aluResult_M  out  N  ALU result
- writeData_M  out  N  forwarded operand B value before the AluSrc mux (store data)

Behaviour:
- Reset (asynchronous, any cycle, including mid-multiply):
  - valid_o = 0 and zero_M = 0.
  - PCBranch_M, aluResult_M and writeData_M = 0.
  - FSM returns to RUN; any in-flight multiply is discarded.
- Operand A = fwdA-mux. Operand B = AluSrc ? signImm_E : fwdB-mux. writeData uses the fwdB-mux output.
- PCBranch = PC_E + (signImm_E << BR_SHIFT), modulo 2^N; overflow is ignored.
- AluControl codes (all results modulo 2^N):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A − B)
  - 0111 pass B
  - 1100 NOR
  - 1000 MUL (optional feature; low N bits of A*B)
  - any other code: result = 0
- Handshake:
  - Transfer in when valid_i && ready_o.
  - ready_o = (state==RUN) && (!valid_o || ready_i).
  - Transfer out when valid_o && ready_i.
  - A simultaneous transfer in and out in the same cycle keeps valid_o = 1 and loads the new result (full throughput).
- Latency: 1 cycle from accepted input to valid_o for non-MUL ops.
- Stall: while valid_o && !ready_i, all outputs hold stable and ready_o = 0.
- Inputs when valid_i = 0 are don't-care and must not change the outputs.
- FSM:
  - RUN → MUL on acceptance of a MUL op (feature enabled).
  - MUL stays for N cycles, then loads the output register, sets valid_o and returns to RUN.
  - The output register is free on acceptance, because ready_o requires it.
  - ready_o = 0 in MUL.
- Forwarded values are sampled at acceptance. Later changes to memResult/wbResult do not affect an in-flight multiply.

Optional Feature:
- Macro EXECUTE_MUL_EN.
- Defined: code 1000 runs a shift-add multiplier. It latches the operands and PCBranch on acceptance and produces the result N cycles after acceptance, i.e. valid_o rises N+1 clock edges after acceptance.
- Undefined: code 1000 is an ordinary single-cycle op with result 0 and zero_M = 1. The MUL state and multiplier logic are absent.

Decomposition:
- Package execute_pkg holds:
  - alu_op_t enum (AND/OR/ADD/SUB/PASSB/NOR/MUL);
  - fwd_sel_t enum (REG, WB, MEM);
  - exe_state_t (RUN, MUL).
- Sub-module mul_iter (N-parameterised, start/busy/done, one partial-product step per cycle) is instantiated only under EXECUTE_MUL_EN.
- The ALU and muxes stay in execute_pipe.

Test Plan:
- Reset mid-MUL (feature on): assert reset at cycle 5 of the multiply → valid_o = 0 and outputs = 0 immediately; ready_o = 1 after reset deasserts.
- ADD with forwarding, N=64:
  - Stimulus: AluSrc=0, fwdA=10 (memResult=5), fwdB=01 (wbResult=7), readData1_E=99, PC_E=0x100, signImm_E=4, ready_i=1.
  - Next cycle: aluResult_M = 12, PCBranch_M = 0x110, writeData_M = 7, zero_M = 0, valid_o = 1.
- SUB equal operands: A = 0x2A, B = 0x2A, AluControl = 0110 → aluResult_M = 0, zero_M = 1. Also AluSrc = 1 with signImm_E = 0xFFFF_FFFF_FFFF_FFFF and A = 1, ADD → result 0 (wrap).
- Back-pressure:
  - Issue an op, then hold ready_i = 0 for 3 cycles while valid_i = 1 with new data.
  - Required: outputs are stable, ready_o = 0, and no input is accepted.
  - When ready_i = 1, the held result transfers and the pending op is accepted the same cycle.
- MUL (feature on, N = 64): A = 3, B = 0xFFFF_FFFF_FFFF_FFFF → aluResult_M = 0xFFFF_FFFF_FFFF_FFFD with valid_o rising 65 clock edges after acceptance. ready_o = 0 throughout, and memResult toggling during the multiply has no effect.
- Illegal/reserved codes: AluControl = 1111 → result 0, zero_M = 1. fwdA = 11 → behaves as readData1_E.
